lightsaber_settings_regs: RTL and testbench
===========================================

Name: lightsaber_settings_regs

Overview:
- Holds the user-selected lightsaber settings: blade colour (RGB), blade configuration, and blade length.
- Inputs are captured on `clk` only while the saber is on (`on`, driven by the on/off register). Outputs hold the last captured values while the saber is off.
- Sits beside the power block. It feeds the display/emitter logic downstream.

Parameters:
- CW, 8, width of each colour channel.
- LIW, 2, width of the whole-units length field (0..3).
- LDW, 6, width of the fractional length field (hundredths, 0..63).
- RST_CFG, 2'd0, reset value of the blade configuration (SINGLE).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- on  in  1  saber-on qualifier; captures inputs when 1.
- r_in  in  CW  red request.
- g_in  in  CW  green request.
- b_in  in  CW  blue request.
- cfg_in  in  2  blade configuration request.
- len_int_in  in  LIW  length whole part.
- len_dec_in  in  LDW  length fractional part (hundredths).
- r_out  out  CW  registered red.
- g_out  out  CW  registered green.
- b_out  out  CW  registered blue.
- cfg_out  out  2  registered configuration.
- len_int_out  out  LIW  registered length whole part.
- len_dec_out  out  LDW  registered length fraction.
- upd  out  1  one-cycle pulse: some output changed on the last edge.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low on `rst`.
  - While `rst`=0, every output is 0, except `cfg_out`, which is RST_CFG. `upd`=0.
- Capture rule:
  - On each rising `clk` with `rst`=1 and `on`=1, every output register loads its input.
  - Latency is 1 cycle from input to output.
- Hold rule:
  - With `on`=0, all outputs hold, whatever the inputs do.
  - Input changes made while off are ignored.
  - When `on` returns to 1, the value present at the next edge is captured.
- Independence:
  - Colour, configuration and length are separate registers sharing one enable.
  - Simultaneous changes to several fields in one cycle are all captured on the same edge.
- Configuration encoding (shared package): 0=SINGLE, 1=CROSSGUARD, 2=DOUBLE, 3=HILTED. All 4 codes are legal and stored as-is.
- Length:
  - Value is `len_int` + `len_dec`/100 ft.
  - Fields are stored without arithmetic, range check or carry.
  - `len_dec` values 0..63 are passed straight through.
- upd:
  - Registered, same reset behaviour as the other outputs.
  - At each capture edge it is set to 1 if any newly loaded value differs from that output's previous value, else 0.
  - It is cleared to 0 on any edge with `on`=0.
- Reset mid-operation: outputs clear immediately (asynchronous). Capture resumes on the first rising edge after `rst` deasserts, if `on`=1.
- No handshake; inputs are level-sampled.

Decomposition:
- Package `lightsaber_pkg`:
  - blade_cfg_t enum (SINGLE, CROSSGUARD, DOUBLE, HILTED).
  - Width constants CW, LIW, LDW.
  - Reset constants.
- Sub-module `setting_reg` (parameterised WIDTH, RST_VAL):
  - Async active-low reset, load when enabled.
  - Outputs q and a changed flag.
  - Instantiated once per field (r, g, b, cfg, len_int, len_dec).
  - The top ORs the changed flags into `upd`.

Test Plan:
- Reset: `rst`=0 with arbitrary inputs -> all colour/length outputs 0, `cfg_out`=0, `upd`=0, asynchronously, with no clock edge required.
- Capture while on: `on`=1, r/g/b=255/47/3, cfg=3, len=1/50 -> next edge gives r/g/b_out=255/47/3, `cfg_out`=3, len_out=1/50, `upd`=1 for one cycle, then 0 if inputs are stable.
- Hold while off:
  - Set `on`=0 and change inputs to 33/255/3, cfg=2, len=2/33 -> outputs stay 255/47/3, 3, 1/50, `upd`=0.
  - Raise `on`=1 -> next edge loads 33/255/3, 2, 2/33 and `upd` pulses.
- Boundary values: `on`=1, colour 0/0/0 then 255/255/255, len 3/63, cfg 0..3 swept -> each value appears one cycle later, unchanged.
- Reset mid-run: assert `rst`=0 between edges while on with captured values -> outputs drop to 0 immediately. Release -> the first edge recaptures the inputs.
- No-change load: `on`=1 with inputs equal to stored values -> outputs unchanged, `upd`=0.

Source files
------------

// File: rtl/lightsaber_settings_regs_pkg.sv
// Shared types and constants for the lightsaber settings block: blade
// configuration encoding, field widths and reset values.
package lightsaber_pkg;

  typedef enum logic [1:0] {
    SINGLE     = 2'd0,
    CROSSGUARD = 2'd1,
    DOUBLE     = 2'd2,
    HILTED     = 2'd3
  } blade_cfg_t;

  localparam int CW  = 8;  // colour channel width
  localparam int LIW = 2;  // whole-units length field
  localparam int LDW = 6;  // hundredths length field

  localparam logic [1:0] RST_CFG = SINGLE;

endpackage

// File: rtl/lightsaber_settings_regs_if.sv
// Settings bus between the user-facing control logic and the settings
// registers: requested values, registered values and the update pulse.
interface lightsaber_settings_regs_if;
  import lightsaber_pkg::*;

  logic           on;
  logic [CW-1:0]  r_in;
  logic [CW-1:0]  g_in;
  logic [CW-1:0]  b_in;
  logic [1:0]     cfg_in;
  logic [LIW-1:0] len_int_in;
  logic [LDW-1:0] len_dec_in;

  logic [CW-1:0]  r_out;
  logic [CW-1:0]  g_out;
  logic [CW-1:0]  b_out;
  logic [1:0]     cfg_out;
  logic [LIW-1:0] len_int_out;
  logic [LDW-1:0] len_dec_out;
  logic           upd;

  modport master (
    output on, r_in, g_in, b_in, cfg_in, len_int_in, len_dec_in,
    input  r_out, g_out, b_out, cfg_out, len_int_out, len_dec_out, upd
  );

  modport slave (
    input  on, r_in, g_in, b_in, cfg_in, len_int_in, len_dec_in,
    output r_out, g_out, b_out, cfg_out, len_int_out, len_dec_out, upd
  );
endinterface

// File: rtl/lightsaber_settings_regs_setting_reg.sv
// One enable-gated settings field with a registered "value changed on the
// last edge" flag.
module setting_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             changed
);

  // NOTE: sequential state uses non-blocking assignments, and only the
  // asynchronous reset joins the clock in the sensitivity list.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= RST_VAL;
      changed <= 1'b0;
    end else if (en) begin
      q       <= d;
      changed <= (d != q);
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: rtl/lightsaber_settings_regs.sv
// Lightsaber settings registers: colour, blade configuration and length,
// captured together while the saber is on and held while it is off.
module lightsaber_settings_regs #(
  parameter int         CW      = lightsaber_pkg::CW,
  parameter int         LIW     = lightsaber_pkg::LIW,
  parameter int         LDW     = lightsaber_pkg::LDW,
  parameter logic [1:0] RST_CFG = lightsaber_pkg::RST_CFG
) (
  input  logic                        clk,
  input  logic                        rst,
  lightsaber_settings_regs_if.slave   bus
);

  logic [5:0] changed;

  setting_reg #(.WIDTH(CW), .RST_VAL('0)) u_r (
    .clk(clk), .rst(rst), .en(bus.on), .d(bus.r_in),
    .q(bus.r_out), .changed(changed[0])
  );

  setting_reg #(.WIDTH(CW), .RST_VAL('0)) u_g (
    .clk(clk), .rst(rst), .en(bus.on), .d(bus.g_in),
    .q(bus.g_out), .changed(changed[1])
  );

  setting_reg #(.WIDTH(CW), .RST_VAL('0)) u_b (
    .clk(clk), .rst(rst), .en(bus.on), .d(bus.b_in),
    .q(bus.b_out), .changed(changed[2])
  );

  setting_reg #(.WIDTH(2), .RST_VAL(RST_CFG)) u_cfg (
    .clk(clk), .rst(rst), .en(bus.on), .d(bus.cfg_in),
    .q(bus.cfg_out), .changed(changed[3])
  );

  // Length halves are stored independently: no carry from hundredths to units.
  setting_reg #(.WIDTH(LIW), .RST_VAL('0)) u_len_int (
    .clk(clk), .rst(rst), .en(bus.on), .d(bus.len_int_in),
    .q(bus.len_int_out), .changed(changed[4])
  );

  setting_reg #(.WIDTH(LDW), .RST_VAL('0)) u_len_dec (
    .clk(clk), .rst(rst), .en(bus.on), .d(bus.len_dec_in),
    .q(bus.len_dec_out), .changed(changed[5])
  );

  assign bus.upd = |changed;

endmodule

// File: tb/tb_lightsaber_settings_regs.sv
// Self-checking bench for lightsaber_settings_regs: a reference model pushes
// expected outputs per edge into a scoreboard, popped at the falling edge.
module tb_lightsaber_settings_regs;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] cfg;
    logic [1:0] li;
    logic [5:0] ld;
  } data_t;

  typedef struct packed {
    data_t d;
    logic  upd;
  } obs_t;

  localparam data_t RST_DATA = '{r: 8'd0, g: 8'd0, b: 8'd0, cfg: 2'd0, li: 2'd0, ld: 6'd0};

  logic clk;
  logic rst;
  lightsaber_settings_regs_if bus ();

  lightsaber_settings_regs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  obs_t  sb[$];
  data_t mdl_d;
  logic  mdl_upd;

  function automatic obs_t sample();
    obs_t o;
    o.d.r   = bus.r_out;
    o.d.g   = bus.g_out;
    o.d.b   = bus.b_out;
    o.d.cfg = bus.cfg_out;
    o.d.li  = bus.len_int_out;
    o.d.ld  = bus.len_dec_out;
    o.upd   = bus.upd;
    return o;
  endfunction

  task automatic set_inputs(input logic o, input data_t v);
    bus.on         = o;
    bus.r_in       = v.r;
    bus.g_in       = v.g;
    bus.b_in       = v.b;
    bus.cfg_in     = v.cfg;
    bus.len_int_in = v.li;
    bus.len_dec_in = v.ld;
  endtask

  // Called at a falling edge: apply inputs, model the next rising edge,
  // queue the expectation, return at the following falling edge.
  task automatic drive(input logic o, input data_t v);
    set_inputs(o, v);
    @(posedge clk);
    if (o) begin
      mdl_upd = (v != mdl_d);
      mdl_d   = v;
    end else begin
      mdl_upd = 1'b0;
    end
    sb.push_back('{d: mdl_d, upd: mdl_upd});
    @(negedge clk);
  endtask

  function automatic data_t mk(input int r, g, b, c, li, ld);
    data_t v;
    v.r = r[7:0]; v.g = g[7:0]; v.b = b[7:0];
    v.cfg = c[1:0]; v.li = li[1:0]; v.ld = ld[5:0];
    return v;
  endfunction

  task automatic test_reset();
    obs_t got;
    rst = 1'b0;
    set_inputs(1'b1, mk(200, 100, 50, 3, 2, 40));
    #2;
    got = sample();
    checks++;
    if (got !== obs_t'{d: RST_DATA, upd: 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h expected %h", got, obs_t'{d: RST_DATA, upd: 1'b0});
    end
    mdl_d   = RST_DATA;
    mdl_upd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_capture();
    obs_t got, exp;
    drive(1'b1, mk(255, 47, 3, 3, 1, 50));
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp || bus.r_out !== 8'd255 || bus.upd !== 1'b1) begin
      errors++;
      $display("FAIL capture: got %h expected %h", got, exp);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk(255, 47, 3, 3, 1, 50));
      exp = sb.pop_front(); got = sample(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL capture_stable[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_hold();
    obs_t got, exp;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, mk(33, 255, 3, 2, 2, 33 + i));
      exp = sb.pop_front(); got = sample(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL hold[%0d]: got %h expected %h", i, got, exp);
      end
    end
    drive(1'b1, mk(33, 255, 3, 2, 2, 33));
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp || bus.upd !== 1'b1) begin
      errors++;
      $display("FAIL hold_resume: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_boundary();
    obs_t  got, exp;
    data_t tbl[6];
    tbl[0] = mk(0, 0, 0, 0, 0, 0);
    tbl[1] = mk(255, 255, 255, 1, 3, 63);
    tbl[2] = mk(255, 255, 255, 2, 3, 63);
    tbl[3] = mk(255, 255, 255, 3, 3, 63);
    tbl[4] = mk(0, 255, 0, 0, 0, 63);
    tbl[5] = mk(255, 0, 255, 3, 3, 0);
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i]);
      exp = sb.pop_front(); got = sample(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL boundary[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    drive(1'b1, mk(12, 34, 56, 2, 1, 7));
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_mid_load: got %h expected %h", got, exp);
    end
    #2 rst = 1'b0;
    #1;
    got = sample(); checks++;
    if (got !== obs_t'{d: RST_DATA, upd: 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_async: got %h expected %h", got, obs_t'{d: RST_DATA, upd: 1'b0});
    end
    mdl_d   = RST_DATA;
    mdl_upd = 1'b0;
    @(posedge clk);
    #1;
    got = sample(); checks++;
    if (got !== obs_t'{d: RST_DATA, upd: 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_held: got %h expected %h", got, obs_t'{d: RST_DATA, upd: 1'b0});
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, mk(12, 34, 56, 2, 1, 7));
    exp = sb.pop_front(); got = sample(); checks++;
    if (got !== exp || bus.upd !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_recapture: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_no_change();
    obs_t got, exp;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, mk(12, 34, 56, 2, 1, 7));
      exp = sb.pop_front(); got = sample(); checks++;
      if (got !== exp || bus.upd !== 1'b0) begin
        errors++;
        $display("FAIL no_change[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t  got, exp;
    data_t v;
    logic  o;
    for (int i = 0; i < 40; i++) begin
      o = ($urandom_range(0, 3) != 0);
      v = mdl_d;
      case ($urandom_range(0, 6))
        0: v.r   = 8'($urandom_range(0, 255));
        1: v.g   = 8'($urandom_range(0, 255));
        2: v.b   = 8'($urandom_range(0, 255));
        3: v.cfg = 2'($urandom_range(0, 3));
        4: v.li  = 2'($urandom_range(0, 3));
        5: v.ld  = 6'($urandom_range(0, 63));
        default: ;
      endcase
      drive(o, v);
      exp = sb.pop_front(); got = sample(); checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_capture();
    test_hold();
    test_boundary();
    test_reset_mid();
    test_no_change();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
